// File: rtl/parity_frame_writer_pkg.sv
// -----------------------------------------------------------------------------
// parity_frame_writer_pkg
// Shared definitions for the parity frame writer and its fetch-side checker:
// default geometry, FSM state encoding and the stored word layout.
// Stored word layout: {data[DATA_W-1:0], P}, P = even parity of data at bit 0.
// -----------------------------------------------------------------------------
package parity_frame_writer_pkg;

  localparam int DATA_W     = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_W     = 4;
  localparam int PARITY_BIT = 0;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  // True when a stored word carries correct even parity; shared with the
  // fetch-side checker.
  function automatic logic word_parity_ok(input logic [DATA_W:0] word);
    return ((^word[DATA_W:1]) == word[PARITY_BIT]);
  endfunction

endpackage

// File: rtl/parity_frame_writer_if.sv
// -----------------------------------------------------------------------------
// parity_frame_writer_if
// Byte write channel into the frame writer (valid/ready handshake).
//   in_data  : byte to store              (master -> slave)
//   in_valid : in_data valid this cycle   (master -> slave)
//   inj_err  : invert stored parity bit   (master -> slave)
//   in_ready : slave can accept           (slave -> master)
// -----------------------------------------------------------------------------
interface parity_frame_writer_if #(
  parameter int DATA_W = parity_frame_writer_pkg::DATA_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              inj_err;
  logic              in_ready;

  modport master (output in_data, output in_valid, output inj_err, input in_ready);
  modport slave  (input in_data, input in_valid, input inj_err, output in_ready);

endinterface

// File: rtl/parity_frame_writer_parity_gen.sv
// -----------------------------------------------------------------------------
// parity_frame_writer_parity_gen
// Combinational even-parity generator with an error-injection input.
//   data_i    : data byte
//   inj_err_i : 1 inverts the generated parity bit
//   parity_o  : XOR of all data bits, XOR inj_err_i
// The fetch-side checker reuses this block with inj_err_i tied low.
// -----------------------------------------------------------------------------
module parity_frame_writer_parity_gen #(
  parameter int DATA_W = parity_frame_writer_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              inj_err_i,
  output logic              parity_o
);

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign parity_o = even_parity(data_i) ^ inj_err_i;

endmodule

// File: rtl/parity_frame_writer.sv
// -----------------------------------------------------------------------------
// parity_frame_writer
// Accepts bytes over a valid/ready channel, appends an even-parity bit and
// stores {data, P} into a DEPTH-entry frame buffer at an auto-incrementing
// address. When DEPTH words have been written the frame is complete: the
// block stops accepting until flush or reset.
//   clk        : clock, all state updates on posedge
//   clear      : synchronous active-low reset (zeroes buffer too)
//   wr_if      : byte write channel (slave side)
//   flush      : abandon current frame, restart at address 0 (memory kept)
//   rd_addr    : combinational read address
//   rd_word    : {data, P} stored at rd_addr
//   wr_ptr     : address of the next write
//   count      : words written in the current frame, 0..DEPTH
//   full       : frame complete
//   frame_done : one-cycle pulse on frame completion
// -----------------------------------------------------------------------------
module parity_frame_writer #(
  parameter int DATA_W = parity_frame_writer_pkg::DATA_W,
  parameter int DEPTH  = parity_frame_writer_pkg::DEPTH,
  parameter int ADDR_W = parity_frame_writer_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  clear,
  parity_frame_writer_if.slave  wr_if,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W:0]       rd_word,
  output logic [ADDR_W-1:0]     wr_ptr,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  frame_done
);

  import parity_frame_writer_pkg::*;

  localparam int CNT_W  = ADDR_W + 1;
  localparam int WORD_W = DATA_W + 1;

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                full_q;
  logic                in_ready_q;
  logic                frame_done_q;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  logic                parity_s;
  logic                accept_s;
  logic                last_word_s;
  logic [WORD_W-1:0]   wr_word_d;

  parity_frame_writer_parity_gen #(
    .DATA_W (DATA_W)
  ) u_parity_gen (
    .data_i    (wr_if.in_data),
    .inj_err_i (wr_if.inj_err),
    .parity_o  (parity_s)
  );

  // Accept qualification and the word to be written; flush drops a
  // simultaneous byte so it never reaches the buffer.
  always_comb begin
    accept_s    = wr_if.in_valid && in_ready_q && !flush;
    last_word_s = (count_q == CNT_W'(DEPTH - 1));
    wr_word_d   = {wr_if.in_data, parity_s};
  end

  // Frame FSM with pointer, counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (flush) begin
        state_q    <= FILL;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        full_q     <= 1'b0;
        in_ready_q <= 1'b1;
      end else begin
        case (state_q)
          FILL: begin
            // Ready comes up here on the first edge after reset release.
            in_ready_q <= 1'b1;
            if (accept_s) begin
              // Pointer wraps naturally to 0 on the last word of the frame.
              wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
              count_q  <= count_q + CNT_W'(1);
              if (last_word_s) begin
                state_q      <= FULL;
                full_q       <= 1'b1;
                in_ready_q   <= 1'b0;
                frame_done_q <= 1'b1;
              end else begin
                state_q <= FILL;
              end
            end else begin
              state_q <= FILL;
            end
          end
          FULL: begin
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end
          default: begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            in_ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Frame buffer: zeroed on reset (all-zero words are parity-correct),
  // written on accept, untouched by flush.
  always_ff @(posedge clk) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept_s) begin
      mem_q[wr_ptr_q] <= wr_word_d;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign rd_word        = mem_q[rd_addr];
  assign wr_ptr         = wr_ptr_q;
  assign count          = count_q;
  assign full           = full_q;
  assign frame_done     = frame_done_q;
  assign wr_if.in_ready = in_ready_q;

endmodule

// File: tb/tb_parity_frame_writer.sv
`timescale 1ns/10ps
// -----------------------------------------------------------------------------
// tb_parity_frame_writer
// Directed bench with a frame-level reference model and a per-cycle compare
// process, plus literal expectations for hand-computed words.
// -----------------------------------------------------------------------------
module tb_parity_frame_writer;

  logic       clk = 1'b0;
  logic       clear;
  logic       flush;
  logic [3:0] rd_addr;
  logic [8:0] rd_word;
  logic [3:0] wr_ptr;
  logic [4:0] count;
  logic       full;
  logic       frame_done;

  parity_frame_writer_if bus ();

  parity_frame_writer dut (
    .clk        (clk),
    .clear      (clear),
    .wr_if      (bus),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rd_word    (rd_word),
    .wr_ptr     (wr_ptr),
    .count      (count),
    .full       (full),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffer image, words in current frame, reset-cycle flag.
  logic [8:0] m_mem [16];
  int         m_words   = 0;
  bit         m_rst     = 1'b1;
  bit         m_done    = 1'b0;
  bit         m_acc     = 1'b0;
  int         acc_total = 0;
  bit         check_en  = 1'b0;
  int         pulses    = 0;

  function automatic bit m_ready();
    return !m_rst && (m_words < 16);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented at it.
  task automatic model_update();
    bit rdy;
    rdy    = m_ready();
    m_acc  = 1'b0;
    m_done = 1'b0;
    if (!clear) begin
      foreach (m_mem[i]) m_mem[i] = 9'h000;
      m_words  = 0;
      m_rst    = 1'b1;
      check_en = 1'b1;
    end else begin
      if (flush) begin
        m_words = 0;
      end else if (bus.in_valid && rdy) begin
        m_mem[m_words % 16] = {bus.in_data, ^{bus.in_data, bus.inj_err}};
        m_words++;
        acc_total++;
        m_acc  = 1'b1;
        m_done = (m_words == 16);
      end
      m_rst = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic inj,
                      input logic fl, input logic clr);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.inj_err  = inj;
    flush        = fl;
    clear        = clr;
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic inj);
    for (int t = 0; t < 8; t++) begin
      step(1'b1, d, inj, 1'b0, 1'b1);
      if (m_acc) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_byte_timeout: byte 0x%0h not accepted, expected accept within 8 cycles", d);
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [8:0] exp);
    rd_addr = a;
    #0.1;
    check(name, 32'(rd_word), 32'(exp));
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("in_ready",   32'(bus.in_ready), 32'(m_ready()));
      check("wr_ptr",     32'(wr_ptr),       32'(m_words % 16));
      check("count",      32'(count),        32'(m_words));
      check("full",       32'(full),         32'(m_words == 16));
      check("frame_done", 32'(frame_done),   32'(m_done));
      check("rd_word",    32'(rd_word),      32'(m_mem[rd_addr]));
      if (frame_done === 1'b1) pulses++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int acc_start;
    clear        = 1'b0;
    flush        = 1'b0;
    rd_addr      = 4'd0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.inj_err  = 1'b0;

    // Reset for two cycles, then release.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_count",    32'(count),        32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("release_ready", 32'(bus.in_ready), 32'd1);

    // Fill a complete frame with 0x00..0x0F.
    pulses = 0;
    for (int b = 0; b < 16; b++) send_byte(8'(b), 1'b0);
    check("fill_full",       32'(full),         32'd1);
    check("fill_frame_done", 32'(frame_done),   32'd1);
    check("fill_count",      32'(count),        32'd16);
    check("fill_wr_ptr",     32'(wr_ptr),       32'd0);
    check("fill_in_ready",   32'(bus.in_ready), 32'd0);
    rd_check("fill_rd3",  4'd3,  9'b00000011_0);
    rd_check("fill_rd7",  4'd7,  9'b00000111_1);
    rd_check("fill_rd15", 4'd15, 9'b00001111_0);

    // Backpressure while full.
    for (int k = 0; k < 5; k++) step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    check("bp_count",  32'(count), 32'd16);
    check("bp_pulses", 32'(pulses), 32'd1);
    rd_check("bp_rd5", 4'd5, 9'b00000101_0);
    rd_check("bp_rd0", 4'd0, 9'b00000000_0);

    // Flush out of FULL, then write with injected parity error.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("flush_count", 32'(count),        32'd0);
    check("flush_ready", 32'(bus.in_ready), 32'd1);
    send_byte(8'h5A, 1'b1);
    rd_check("inj_rd0", 4'd0, 9'b01011010_1);

    // Flush has priority over a simultaneous accept.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    check("fp_count",  32'(count),  32'd0);
    check("fp_wr_ptr", 32'(wr_ptr), 32'd0);
    rd_check("fp_rd0", 4'd0, 9'b00010001_0);
    rd_check("fp_rd1", 4'd1, 9'b00100010_0);
    rd_check("fp_rd2", 4'd2, 9'b00110011_0);
    rd_check("fp_rd3", 4'd3, 9'b00000011_0);

    // Reset in the middle of a frame.
    for (int b = 0; b < 5; b++) send_byte(8'(8'h41 + b), 1'b0);
    check("mid_count", 32'(count), 32'd5);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_count", 32'(count),        32'd0);
    check("mid_rst_full",  32'(full),         32'd0);
    for (int a = 0; a < 16; a++) rd_check("mid_rst_zero", 4'(a), 9'h000);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("mid_release_ready", 32'(bus.in_ready), 32'd1);

    // Gapped valid: 32 cycles, valid on even cycles only.
    acc_start = acc_total;
    pulses    = 0;
    for (int k = 0; k < 32; k++) begin
      step((k % 2) == 0, 8'(8'h30 + k), 1'b0, 1'b0, 1'b1);
      if (k == 29) check("gap_not_full_yet", 32'(full), 32'd0);
      if (k == 30) begin
        check("gap_full",       32'(full),       32'd1);
        check("gap_frame_done", 32'(frame_done), 32'd1);
      end
    end
    check("gap_accepts", 32'(acc_total - acc_start), 32'd16);
    check("gap_pulses",  32'(pulses),                32'd1);
    check("gap_count",   32'(count),                 32'd16);
    check("gap_wr_ptr",  32'(wr_ptr),                32'd0);
    rd_check("gap_rd4", 4'd4, 9'b00111000_1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
